multiport_memory: RTL

MULTIPORT_MEMORY -- requirements
Module: multiport_memory

---
 rtl/multiport_memory_pkg.sv | 26 ++
 rtl/multiport_memory_rport.sv | 79 +++++++
 rtl/multiport_memory.sv | 100 ++++++++++
 3 files changed

// File: rtl/multiport_memory_pkg.sv
// Shared constants and the byte-merge helper for multiport_memory.
// byte_merge works on MERGE_W_MAX-bit words; callers size-cast in and out.
package multiport_memory_pkg;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 2;
  localparam int unsigned NREAD_MIN      = 1;
  localparam int unsigned NREAD_MAX      = 4;
  localparam int unsigned MERGE_W_MAX    = 1024;
  localparam int unsigned STRB_W_MAX     = MERGE_W_MAX / 8;

  // Bytes of new_word replace old_word wherever the matching strobe is set.
  function automatic logic [MERGE_W_MAX-1:0] byte_merge(
    input logic [MERGE_W_MAX-1:0] old_word,
    input logic [MERGE_W_MAX-1:0] new_word,
    input logic [STRB_W_MAX-1:0]  strb
  );
    logic [MERGE_W_MAX-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < STRB_W_MAX; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/multiport_memory_rport.sv
// One read port: write-to-read forwarding, RD_LATENCY pipeline, valid pulse
// and (with MULTIPORT_MEMORY_PARITY_EN) the parity check.
module multiport_memory_rport
  import multiport_memory_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             hit_i,
  input  logic [WIDTH-1:0] mem_word_i,
  input  logic [WIDTH-1:0] fwd_word_i,
`ifdef MULTIPORT_MEMORY_PARITY_EN
  input  logic             mem_par_i,
`endif
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             err_o
);

  logic [WIDTH-1:0] samp_word;
  logic             samp_err;
  logic             pipe_v;
  logic             pipe_e;
  logic [WIDTH-1:0] pipe_d;

  assign samp_word = hit_i ? fwd_word_i : mem_word_i;

`ifdef MULTIPORT_MEMORY_PARITY_EN
  // Forwarded words never touched the stored parity bit, so they cannot flag.
  assign samp_err = !hit_i && ((^mem_word_i) != mem_par_i);
`else
  assign samp_err = 1'b0;
`endif

  if (RD_LATENCY == RD_LATENCY_MAX) begin : g_lat2
    logic             s1_v;
    logic             s1_e;
    logic [WIDTH-1:0] s1_d;

    // The word is captured at the request edge; later writes cannot reach it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_v <= 1'b0;
        s1_e <= 1'b0;
        s1_d <= '0;
      end else begin
        s1_v <= req_i;
        if (req_i) begin
          s1_d <= samp_word;
          s1_e <= samp_err;
        end
      end
    end

    assign pipe_v = s1_v;
    assign pipe_e = s1_e;
    assign pipe_d = s1_d;
  end else begin : g_lat1
    assign pipe_v = req_i;
    assign pipe_e = samp_err;
    assign pipe_d = samp_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= pipe_v;
      err_o   <= pipe_v && pipe_e;
      if (pipe_v) data_o <= pipe_d;
    end
  end

endmodule

// File: rtl/multiport_memory.sv
// Word memory with NREAD independent read ports, one byte-strobed write port
// and same-cycle write forwarding. Optional parity: MULTIPORT_MEMORY_PARITY_EN.
module multiport_memory
  import multiport_memory_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      DEPTH      = 1024,
  parameter int unsigned      NREAD      = 2,
  parameter int unsigned      RD_LATENCY = 1,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0,
  localparam int unsigned     AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned     SW         = WIDTH / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NREAD-1:0]            read_en_i,
  input  logic [NREAD-1:0][AW-1:0]    read_pos_i,
  output logic [NREAD-1:0][WIDTH-1:0] read_data_o,
  output logic [NREAD-1:0]            read_valid_o,
  input  logic                        write_en_i,
  input  logic [AW-1:0]               write_pos_i,
  input  logic [WIDTH-1:0]            write_data_i,
  input  logic [SW-1:0]               write_strb_i,
  output logic [NREAD-1:0]            parity_err_o
);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("multiport_memory: RD_LATENCY must be 1 or 2");
  end
  if (NREAD < NREAD_MIN || NREAD > NREAD_MAX) begin : g_bad_nread
    $error("multiport_memory: NREAD must be 1..4");
  end
  if (WIDTH == 0 || (WIDTH % 8) != 0 || WIDTH > MERGE_W_MAX) begin : g_bad_width
    $error("multiport_memory: WIDTH must be a non-zero multiple of 8");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire;
  logic [WIDTH-1:0] wr_word;

  assign wr_fire = write_en_i && (write_strb_i != '0) && (32'(write_pos_i) < DEPTH);
  assign wr_word = WIDTH'(byte_merge(MERGE_W_MAX'(mem_q[write_pos_i]),
                                     MERGE_W_MAX'(write_data_i),
                                     STRB_W_MAX'(write_strb_i)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VAL;
    end else if (wr_fire) begin
      mem_q[write_pos_i] <= wr_word;
    end
  end

`ifdef MULTIPORT_MEMORY_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) par_q[i] <= ^INIT_VAL;
    end else if (wr_fire) begin
      par_q[write_pos_i] <= ^wr_word;
    end
  end
`endif

  for (genvar p = 0; p < NREAD; p++) begin : g_rport
    logic             in_range;
    logic             hit;
    logic [WIDTH-1:0] mem_word;

    assign in_range = 32'(read_pos_i[p]) < DEPTH;
    // wr_fire already implies an in-range write, so a hit implies an in-range read.
    assign hit      = wr_fire && (write_pos_i == read_pos_i[p]);
    assign mem_word = in_range ? mem_q[read_pos_i[p]] : '0;

`ifdef MULTIPORT_MEMORY_PARITY_EN
    logic par_bit;
    assign par_bit = in_range ? par_q[read_pos_i[p]] : 1'b0;
`endif

    multiport_memory_rport #(
      .WIDTH      (WIDTH),
      .RD_LATENCY (RD_LATENCY)
    ) u_rport (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (read_en_i[p]),
      .hit_i      (hit),
      .mem_word_i (mem_word),
      .fwd_word_i (wr_word),
`ifdef MULTIPORT_MEMORY_PARITY_EN
      .mem_par_i  (par_bit),
`endif
      .data_o     (read_data_o[p]),
      .valid_o    (read_valid_o[p]),
      .err_o      (parity_err_o[p])
    );
  end

endmodule
